memwb_pipe_reg: RTL

Parametrised MEM/WB pipeline register for the RISC-V core, replacing the free-running MEM/WB latch. It captures data-memory read data, ALU result, destination register and write-back control from the MEM stage. It adds valid/ready flow control with a one-entry skid buffer, flush, the write-back data mux, a gated register-file write enable, and a saturating back-pressure counter. It sits between the MEM stage and the register-file write port / forwarding unit.

---
 rtl/memwb_pkg.sv | 24 ++
 rtl/memwb_pipe_reg_skid.sv | 59 +++++
 rtl/memwb_pipe_reg.sv | 76 +++++++
 3 files changed

// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: write-back control bit
// positions and the packed entry layout carried through the skid buffer.
package memwb_pkg;

  localparam int WB_CTRL_W    = 2;
  localparam int WB_REG_WRITE = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam int MEMWB_XLEN = 64;
  localparam int MEMWB_RA_W = 5;

  typedef struct packed {
    logic [MEMWB_XLEN-1:0] dm_data;
    logic [MEMWB_XLEN-1:0] alu_result;
    logic [MEMWB_RA_W-1:0] rd;
    logic [WB_CTRL_W-1:0]  wb_ctrl;
  } memwb_entry_t;

  // Flat payload width for an entry of arbitrary XLEN/RA_W, same field order as memwb_entry_t.
  function automatic int entry_width(input int xlen, input int ra_w);
    return 2 * xlen + ra_w + WB_CTRL_W;
  endfunction

endpackage

// File: rtl/memwb_pipe_reg_skid.sv
// Generic one-entry skid buffer: a main slot driving the outputs plus a skid
// slot that absorbs the entry accepted in the first back-pressured cycle.
module pipe_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_reg;
  logic             skid_valid_reg;
  logic [WIDTH-1:0] main_data_reg;
  logic [WIDTH-1:0] skid_data_reg;

  logic accept;
  logic transfer;

  assign in_ready  = !skid_valid_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign accept    = in_valid && !skid_valid_reg;
  assign transfer  = main_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      // Payloads are left stale; only the valid bits matter after a flush.
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || transfer) begin
      // A valid skid implies in_ready=0, so no accept can collide with the drain.
      if (skid_valid_reg) begin
        main_data_reg  <= skid_data_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_data_reg  <= in_data;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_data_reg  <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready flow control, flush, write-back
// data mux, x0-gated register-file write enable and a saturating stall counter.
module memwb_pipe_reg
  import memwb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      dm_data_in,
  input  logic [XLEN-1:0]      alu_result_in,
  input  logic [RA_W-1:0]      rd_in,
  input  logic [WB_CTRL_W-1:0] wb_ctrl_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      dm_data_out,
  output logic [XLEN-1:0]      alu_result_out,
  output logic [RA_W-1:0]      rd_out,
  output logic [WB_CTRL_W-1:0] wb_ctrl_out,
  output logic [XLEN-1:0]      wb_data_out,
  output logic                 rf_we_out,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int ENTRY_W = entry_width(XLEN, RA_W);

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   stall_cnt_next;

  assign in_entry = {dm_data_in, alu_result_in, rd_in, wb_ctrl_in};
  assign {dm_data_out, alu_result_out, rd_out, wb_ctrl_out} = out_entry;

  pipe_skid_buf #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_entry)
  );

  assign wb_data_out = wb_ctrl_out[WB_MEM_TO_REG] ? dm_data_out : alu_result_out;
  // x0 is hardwired to zero, so a write to it is never enabled.
  assign rf_we_out   = out_valid && wb_ctrl_out[WB_REG_WRITE] && (rd_out != '0);

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule
